// File: rtl/alt_mem_ddrx_mm_burst_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the MM-to-ST converter slave port.
// Round-robin per command. A write burst keeps the grant until every beat has
// been accepted. A tag FIFO records read return order, so each returned beat
// is routed back to the requester that issued the read.
// Optional build macro: MM_ARB_FIXED_PRIO_EN. When it is defined, port 0 always
// wins a tie. When it is undefined, ties are resolved round-robin.
module alt_mem_ddrx_mm_burst_arbiter #(
  parameter int unsigned AVL_SIZE_WIDTH = 3,
  parameter int unsigned AVL_ADDR_WIDTH = 25,
  parameter int unsigned AVL_DATA_WIDTH = 32,
  parameter int unsigned RD_TAG_AWIDTH  = 3
) (
  input  logic                          ctl_clk,
  input  logic                          ctl_reset,

  output logic                          p0_ready,
  input  logic                          p0_read_req,
  input  logic                          p0_write_req,
  input  logic [AVL_SIZE_WIDTH-1:0]     p0_size,
  input  logic [AVL_ADDR_WIDTH-1:0]     p0_addr,
  input  logic [AVL_DATA_WIDTH-1:0]     p0_wdata,
  input  logic [AVL_DATA_WIDTH/8-1:0]   p0_be,
  output logic                          p0_rdata_valid,
  output logic [AVL_DATA_WIDTH-1:0]     p0_rdata,

  output logic                          p1_ready,
  input  logic                          p1_read_req,
  input  logic                          p1_write_req,
  input  logic [AVL_SIZE_WIDTH-1:0]     p1_size,
  input  logic [AVL_ADDR_WIDTH-1:0]     p1_addr,
  input  logic [AVL_DATA_WIDTH-1:0]     p1_wdata,
  input  logic [AVL_DATA_WIDTH/8-1:0]   p1_be,
  output logic                          p1_rdata_valid,
  output logic [AVL_DATA_WIDTH-1:0]     p1_rdata,

  input  logic                          avl_ready,
  output logic                          avl_read_req,
  output logic                          avl_write_req,
  output logic [AVL_SIZE_WIDTH-1:0]     avl_size,
  output logic [AVL_ADDR_WIDTH-1:0]     avl_addr,
  output logic [AVL_DATA_WIDTH-1:0]     avl_wdata,
  output logic [AVL_DATA_WIDTH/8-1:0]   avl_be,
  input  logic                          avl_rdata_valid,
  input  logic [AVL_DATA_WIDTH-1:0]     avl_rdata,

  output logic                          arb_rd_orphan
);

  localparam int unsigned AVL_BE_WIDTH = AVL_DATA_WIDTH / 8;
  localparam int unsigned TAG_DEPTH    = 1 << RD_TAG_AWIDTH;
  localparam int unsigned TAG_CNT_W    = RD_TAG_AWIDTH + 1;
  localparam int unsigned BEAT_W       = AVL_SIZE_WIDTH + 1;

  typedef struct packed {
    logic                      port;
    logic [AVL_SIZE_WIDTH-1:0] size;
  } rd_tag_t;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WR_BURST = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic                      burst_owner, burst_owner_nxt;
  logic [AVL_SIZE_WIDTH-1:0] burst_cnt, burst_cnt_nxt;
`ifndef MM_ARB_FIXED_PRIO_EN
  logic                      last_grant;
`endif

  rd_tag_t                   tag_mem [TAG_DEPTH];
  logic [RD_TAG_AWIDTH-1:0]  tag_wr_ptr, tag_rd_ptr;
  logic [TAG_CNT_W-1:0]      tag_cnt;
  logic [AVL_SIZE_WIDTH-1:0] beat_cnt;

  logic                      run;
  logic                      req0, req1;
  logic                      grant;
  logic                      gnt_read, gnt_write, gnt_ready;
  logic [AVL_SIZE_WIDTH-1:0] gnt_size;
  logic                      rd_acc, wr_acc, first_wr_acc;
  logic                      tag_full, tag_empty;
  logic                      tag_push, tag_pop;
  rd_tag_t                   tag_head, tag_new;
  logic                      ret_hit, beat_last;
  logic [BEAT_W-1:0]         beat_inc;

  assign run  = ~ctl_reset;
  assign req0 = p0_read_req | p0_write_req;
  assign req1 = p1_read_req | p1_write_req;

  // Grant select: a burst stays locked to its owner, otherwise tie-break between requesters
  always_comb begin
    grant = 1'b0;
    if (state == ST_WR_BURST) begin
      grant = burst_owner;
    end else if (req0 && req1) begin
`ifdef MM_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_grant;
`endif
    end else if (req1) begin
      grant = 1'b1;
    end
  end

  // Command mux from the granted requester onto the converter port
  always_comb begin
    gnt_read  = grant ? p1_read_req  : p0_read_req;
    gnt_write = grant ? p1_write_req : p0_write_req;
    gnt_size  = grant ? p1_size      : p0_size;
    avl_size  = gnt_size;
    avl_addr  = grant ? p1_addr      : p0_addr;
    avl_wdata = grant ? p1_wdata     : p0_wdata;
    avl_be    = grant ? p1_be        : p0_be;
  end

  assign tag_full  = (tag_cnt == TAG_CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);

  assign avl_read_req  = run & gnt_read & ~tag_full;
  assign avl_write_req = run & gnt_write;
  assign gnt_ready     = run & avl_ready & ~(gnt_read & tag_full);
  assign p0_ready      = gnt_ready & ~grant;
  assign p1_ready      = gnt_ready &  grant;

  assign rd_acc       = gnt_ready & gnt_read;
  assign wr_acc       = gnt_ready & gnt_write;
  assign first_wr_acc = wr_acc & (state == ST_IDLE);

  // A burstcount of zero still returns one beat
  assign tag_new.port = grant;
  assign tag_new.size = (gnt_size == '0) ? AVL_SIZE_WIDTH'(1) : gnt_size;
  assign tag_push     = rd_acc;

  // Return routing: the head tag selects the destination requester
  assign tag_head  = tag_mem[tag_rd_ptr];
  assign ret_hit   = avl_rdata_valid & ~tag_empty;
  assign beat_inc  = BEAT_W'(beat_cnt) + BEAT_W'(1);
  assign beat_last = (beat_inc == BEAT_W'(tag_head.size));
  assign tag_pop   = ret_hit & beat_last;

  assign p0_rdata_valid = ret_hit & ~tag_head.port;
  assign p1_rdata_valid = ret_hit &  tag_head.port;
  assign p0_rdata       = avl_rdata;
  assign p1_rdata       = avl_rdata;
  assign arb_rd_orphan  = run & avl_rdata_valid & tag_empty;

  // Burst FSM next-state and burst bookkeeping
  always_comb begin
    state_nxt       = state;
    burst_owner_nxt = burst_owner;
    burst_cnt_nxt   = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (wr_acc && (gnt_size > AVL_SIZE_WIDTH'(1))) begin
          state_nxt       = ST_WR_BURST;
          burst_owner_nxt = grant;
          burst_cnt_nxt   = gnt_size - AVL_SIZE_WIDTH'(1);
        end
      end
      ST_WR_BURST: begin
        if (wr_acc) begin
          burst_cnt_nxt = burst_cnt - AVL_SIZE_WIDTH'(1);
          if (burst_cnt == AVL_SIZE_WIDTH'(1)) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM and burst state registers
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      state       <= ST_IDLE;
      burst_owner <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      burst_owner <= burst_owner_nxt;
      burst_cnt   <= burst_cnt_nxt;
    end
  end

`ifndef MM_ARB_FIXED_PRIO_EN
  // Round-robin history: updated on a read or the first beat of a write
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      last_grant <= 1'b1;
    end else if (rd_acc || first_wr_acc) begin
      last_grant <= grant;
    end
  end
`endif

  // Tag FIFO storage
  always_ff @(posedge ctl_clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr] <= tag_new;
    end
  end

  // Tag FIFO pointers, occupancy and per-read beat counter
  always_ff @(posedge ctl_clk or posedge ctl_reset) begin
    if (ctl_reset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      if (tag_push) begin
        tag_wr_ptr <= tag_wr_ptr + RD_TAG_AWIDTH'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr <= tag_rd_ptr + RD_TAG_AWIDTH'(1);
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + TAG_CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - TAG_CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (tag_pop) begin
        beat_cnt <= '0;
      end else if (ret_hit) begin
        beat_cnt <= beat_cnt + AVL_SIZE_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alt_mem_ddrx_mm_burst_arbiter.sv
// Directed bench for alt_mem_ddrx_mm_burst_arbiter. The expectations follow
// the MM_ARB_FIXED_PRIO_EN setting.
module tb_alt_mem_ddrx_mm_burst_arbiter;

  localparam int unsigned SW = 3;
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 32;

  logic          ctl_clk, ctl_reset;
  logic          p0_ready, p0_read_req, p0_write_req, p0_rdata_valid;
  logic [SW-1:0] p0_size;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic [DW/8-1:0] p0_be;
  logic          p1_ready, p1_read_req, p1_write_req, p1_rdata_valid;
  logic [SW-1:0] p1_size;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [DW/8-1:0] p1_be;
  logic          avl_ready, avl_read_req, avl_write_req, avl_rdata_valid;
  logic [SW-1:0] avl_size;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata, avl_rdata;
  logic [DW/8-1:0] avl_be;
  logic          arb_rd_orphan;

  int errors;
  int checks;

  localparam logic [AW-1:0] A0 = 25'h00000A0;
  localparam logic [AW-1:0] A1 = 25'h00001B1;
  localparam logic [AW-1:0] AW0 = 25'h00000C0;

  alt_mem_ddrx_mm_burst_arbiter dut (
    .ctl_clk(ctl_clk), .ctl_reset(ctl_reset),
    .p0_ready(p0_ready), .p0_read_req(p0_read_req), .p0_write_req(p0_write_req),
    .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_rdata_valid(p0_rdata_valid), .p0_rdata(p0_rdata),
    .p1_ready(p1_ready), .p1_read_req(p1_read_req), .p1_write_req(p1_write_req),
    .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_rdata_valid(p1_rdata_valid), .p1_rdata(p1_rdata),
    .avl_ready(avl_ready), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_size(avl_size), .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .arb_rd_orphan(arb_rd_orphan)
  );

  initial ctl_clk = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_reqs();
    p0_read_req = 1'b0; p0_write_req = 1'b0;
    p1_read_req = 1'b0; p1_write_req = 1'b0;
  endtask

  logic rr_port [4];
  logic [5:0] rdy_seq;

  initial begin
    errors = 0; checks = 0;
    clear_reqs();
    p0_size = 3'd1; p1_size = 3'd1;
    p0_addr = A0;   p1_addr = A1;
    p0_wdata = '0;  p1_wdata = 32'h5555_5555;
    p0_be = 4'hF;   p1_be = 4'h3;
    avl_ready = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
    ctl_reset = 1'b0;
    #2 ctl_reset = 1'b1;

    // Reset held with both ports requesting
    @(negedge ctl_clk);
    p0_read_req = 1'b1; p1_read_req = 1'b1; avl_ready = 1'b1; avl_rdata_valid = 1'b1;
    #1;
    check("rst_p0_ready", 64'(p0_ready), 64'd0);
    check("rst_p1_ready", 64'(p1_ready), 64'd0);
    check("rst_avl_read_req", 64'(avl_read_req), 64'd0);
    check("rst_avl_write_req", 64'(avl_write_req), 64'd0);
    check("rst_p0_rdata_valid", 64'(p0_rdata_valid), 64'd0);
    check("rst_p1_rdata_valid", 64'(p1_rdata_valid), 64'd0);
    check("rst_orphan", 64'(arb_rd_orphan), 64'd0);

    @(negedge ctl_clk);
    ctl_reset = 1'b0; clear_reqs(); avl_rdata_valid = 1'b0;

    // Both ports issue single-beat reads every cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge ctl_clk);
      p0_read_req = 1'b1; p1_read_req = 1'b1; avl_ready = 1'b1;
`ifdef MM_ARB_FIXED_PRIO_EN
      rr_port[k] = 1'b0;
`else
      rr_port[k] = 1'(k % 2);
`endif
      #1;
      check($sformatf("rr_addr_%0d", k), 64'(avl_addr), rr_port[k] ? 64'(A1) : 64'(A0));
      check($sformatf("rr_p0_ready_%0d", k), 64'(p0_ready), 64'(!rr_port[k]));
      check($sformatf("rr_p1_ready_%0d", k), 64'(p1_ready), 64'(rr_port[k]));
      check($sformatf("rr_rd_req_%0d", k), 64'(avl_read_req), 64'd1);
    end
    @(negedge ctl_clk);
    clear_reqs();
    for (int j = 0; j < 4; j++) begin
      @(negedge ctl_clk);
      avl_rdata_valid = 1'b1; avl_rdata = 32'hD000_0000 + 32'(j);
      #1;
      check($sformatf("ret_p0_valid_%0d", j), 64'(p0_rdata_valid), 64'(!rr_port[j]));
      check($sformatf("ret_p1_valid_%0d", j), 64'(p1_rdata_valid), 64'(rr_port[j]));
      check($sformatf("ret_p1_rdata_%0d", j), 64'(p1_rdata), 64'(32'hD000_0000 + 32'(j)));
    end
    @(negedge ctl_clk);
    avl_rdata_valid = 1'b0;

    // p0 size-4 write burst, p1 read waiting behind it
    rdy_seq = 6'b101101;  // bit c = avl_ready in cycle c: 1,0,1,1,0,1
    p0_addr = AW0; p0_size = 3'd4; p1_size = 3'd1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ctl_clk);
      p0_write_req = 1'b1; p1_read_req = 1'b1;
      avl_ready = rdy_seq[c];
      p0_wdata = 32'hA000_0000 + 32'(c);
      #1;
      check($sformatf("bl_wr_req_%0d", c), 64'(avl_write_req), 64'd1);
      check($sformatf("bl_rd_req_%0d", c), 64'(avl_read_req), 64'd0);
      check($sformatf("bl_p0_ready_%0d", c), 64'(p0_ready), 64'(rdy_seq[c]));
      check($sformatf("bl_p1_ready_%0d", c), 64'(p1_ready), 64'd0);
      check($sformatf("bl_wdata_%0d", c), 64'(avl_wdata), 64'(32'hA000_0000 + 32'(c)));
      check($sformatf("bl_size_%0d", c), 64'(avl_size), 64'd4);
    end
    @(negedge ctl_clk);
    p0_write_req = 1'b0; avl_ready = 1'b1;
    #1;
    check("bl_p1_granted_ready", 64'(p1_ready), 64'd1);
    check("bl_p1_granted_rd_req", 64'(avl_read_req), 64'd1);
    check("bl_p1_granted_addr", 64'(avl_addr), 64'(A1));
    check("bl_p1_granted_wr_req", 64'(avl_write_req), 64'd0);
    @(negedge ctl_clk);
    p1_read_req = 1'b0; avl_rdata_valid = 1'b1;
    #1;
    check("bl_ret_p1_valid", 64'(p1_rdata_valid), 64'd1);
    check("bl_ret_p0_valid", 64'(p0_rdata_valid), 64'd0);
    @(negedge ctl_clk);
    avl_rdata_valid = 1'b0;

    // Fill the tag FIFO with eight size-2 reads
    p0_addr = A0; p0_size = 3'd2;
    for (int i = 0; i < 8; i++) begin
      @(negedge ctl_clk);
      p0_read_req = 1'b1; avl_ready = 1'b1;
      #1;
      check($sformatf("full_fill_ready_%0d", i), 64'(p0_ready), 64'd1);
      check($sformatf("full_fill_rd_req_%0d", i), 64'(avl_read_req), 64'd1);
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge ctl_clk);
      avl_rdata_valid = 1'b1;
      #1;
      check($sformatf("full_ready_%0d", b), 64'(p0_ready), 64'd0);
      check($sformatf("full_rd_req_%0d", b), 64'(avl_read_req), 64'd0);
      check($sformatf("full_ret_valid_%0d", b), 64'(p0_rdata_valid), 64'd1);
    end
    @(negedge ctl_clk);
    avl_rdata_valid = 1'b0;
    #1;
    check("full_9th_ready", 64'(p0_ready), 64'd1);
    check("full_9th_rd_req", 64'(avl_read_req), 64'd1);
    @(negedge ctl_clk);
    clear_reqs();

    // Reset with reads outstanding, then a return with nothing pending
    ctl_reset = 1'b1;
    @(negedge ctl_clk);
    ctl_reset = 1'b0; avl_rdata_valid = 1'b1;
    #1;
    check("orphan_pulse", 64'(arb_rd_orphan), 64'd1);
    check("orphan_p0_valid", 64'(p0_rdata_valid), 64'd0);
    check("orphan_p1_valid", 64'(p1_rdata_valid), 64'd0);
    @(negedge ctl_clk);
    avl_rdata_valid = 1'b0;
    #1;
    check("orphan_clear", 64'(arb_rd_orphan), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
